issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised issue stage between the reservation stations and the execution units. It replaces the flush-gated pass-through with one independent FIFO per execution channel. Each FIFO has valid/ready handshakes on both sides and synchronous whole-pipeline flush. Optional same-cycle bypass is available when a FIFO is empty. Channel i feeds execution unit i; there is no ordering between channels.

## Interface
Parameters:
- NUM_CH, 3, number of issue channels (0 = ALU, 1 = LS, 2 = BRANCH by convention)
- DEPTH, 2, entries per channel FIFO; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset synchronous and active-high
- flush  in  1  kill all buffered and in-flight issue entries
- in_entry  in  RS_ENTRY_t [NUM_CH]  entry from reservation station per channel
- in_valid  in  [NUM_CH]  entry offered
- in_ready  out  [NUM_CH]  channel can accept
- out_entry  out  RS_ENTRY_t [NUM_CH]  entry to execution unit
- out_valid  out  [NUM_CH]  out_entry is live
- out_ready  in  [NUM_CH]  execution unit consumes
- occupancy  out  [NUM_CH][CNT_W]  entries currently held per channel
- all_empty  out  1  every channel's occupancy is 0

## Operation
- Per channel: circular buffer of DEPTH entries, read/write pointers of $clog2(DEPTH) bits, count of CNT_W bits.
- Pointers wrap naturally modulo DEPTH.
- Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the rising edge.
- in_ready = !rst & !flush & (count != DEPTH). It depends only on registered state plus flush, never on out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = !flush & (count != 0); out_entry = slot[rd_ptr]. With bypass enabled, see Configuration.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
- Full: in_ready = 0 and the upstream holds its entry. A pop during full does not enable a push in the same cycle.
- Empty: out_valid = 0 (without bypass).
- Flush, applied in the flush cycle and at the following edge:
  - in_ready and out_valid are forced to 0 in the flush cycle, so no push or pop happens.
  - At the edge, all pointers and counts go to 0.
  - Entries accepted in earlier cycles are discarded.
- rst has priority over flush; both produce the same cleared state.
- Channels are fully independent; one channel stalling never affects another.
- out_entry is don't-care while out_valid = 0. The bench must not check it.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 0 while rst is high and 1 from the first cycle after rst falls.
  - occupancy = 0, all_empty = 1.
- Latency without bypass: an entry pushed at edge N is visible on out_valid/out_entry in the cycle after edge N, i.e. one cycle.
- Throughput: one entry per channel per cycle in steady state when out_ready is held at 1.
- occupancy and all_empty are registered-state derived. They update on the edge after a push/pop/flush.
- Flush asserted while an entry is being offered: that entry is not accepted. The upstream is responsible for dropping it, since it is flushed too.

## Configuration
- ISSUE_BYPASS_EN defined:
  - When a channel has count = 0, in_valid = 1, out_ready = 1 and flush = 0, then out_valid = 1 and out_entry = in_entry combinationally.
  - The entry is consumed with no write, and count stays 0. This gives zero-cycle latency.
  - in_ready is still !full, and out_valid = !flush & (count != 0 | in_valid).
- ISSUE_BYPASS_EN not defined: no combinational in→out path; latency is always ≥ 1 cycle.

## Structure
- typedef_pkg holds:
  - RS_ENTRY_t (existing).
  - Channel index constants ISSUE_CH_ALU = 0, ISSUE_CH_LS = 1, ISSUE_CH_BR = 2.
  - ISSUE_NUM_CH = 3.
- One sub-module, issue_fifo (single-channel FIFO with flush, count and optional bypass), instantiated NUM_CH times in a generate loop.
- The top level only adds the all_empty reduction.

## Test plan
- Reset release, no traffic → in_ready = 3'b111, out_valid = 0, occupancy all 0, all_empty = 1.
- ALU channel: push A at edge 1 with out_ready = 0 → out_valid[0] = 1, out_entry[0] = A from cycle 2, occupancy[0] = 1. Without bypass, A is never visible in cycle 1.
- LS channel, DEPTH = 2, out_ready = 0, push A, B, C on consecutive cycles:
  - A and B are accepted; C waits with in_ready[1] = 0 and occupancy[1] = 2.
  - Raise out_ready → A, then B, then C drain in order.
  - Pointers wrap with no loss.
- Simultaneous push/pop at occupancy 1 for 8 cycles → occupancy stays 1, entries emerge in FIFO order, one per cycle.
- Fill all channels, assert flush for 1 cycle with in_valid = 1:
  - In the flush cycle, out_valid = 0 and in_ready = 0.
  - Next cycle, occupancy is all 0 and all_empty = 1.
  - The entry offered during flush never appears.
- With ISSUE_BYPASS_EN, empty BR channel, in_valid = out_ready = 1 with entry X → out_valid[2] = 1 and out_entry[2] = X in the same cycle, occupancy[2] stays 0.

Source files
------------

// File: rtl/typedef_pkg.sv
// rtl/typedef_pkg.sv - shared issue-stage types and channel index constants
package typedef_pkg;

    typedef struct packed {
        logic [5:0]  rob_tag;
        logic [7:0]  opcode;
        logic [31:0] src_a;
        logic [31:0] src_b;
    } RS_ENTRY_t;

    localparam int ISSUE_NUM_CH = 3;
    localparam int ISSUE_CH_ALU = 0;
    localparam int ISSUE_CH_LS  = 1;
    localparam int ISSUE_CH_BR  = 2;

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - per-channel issue handshakes, RS side and execution side
interface issue_queue_if
    import typedef_pkg::*;
#(
    parameter int NUM_CH = ISSUE_NUM_CH
);
    RS_ENTRY_t [NUM_CH-1:0] in_entry;
    logic      [NUM_CH-1:0] in_valid;
    logic      [NUM_CH-1:0] in_ready;
    RS_ENTRY_t [NUM_CH-1:0] out_entry;
    logic      [NUM_CH-1:0] out_valid;
    logic      [NUM_CH-1:0] out_ready;

    modport master (
        output in_entry, in_valid, out_ready,
        input  in_ready, out_entry, out_valid
    );

    modport slave (
        input  in_entry, in_valid, out_ready,
        output in_ready, out_entry, out_valid
    );
endinterface

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - single-channel issue FIFO with flush and occupancy count
// Optional zero-latency bypass when empty: ISSUE_BYPASS_EN.
module issue_fifo
    import typedef_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  RS_ENTRY_t        in_entry,
    input  logic             in_valid,
    output logic             in_ready,
    output RS_ENTRY_t        out_entry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    RS_ENTRY_t        slot [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // in_ready is built from registered state only, so out_ready never reaches it
    assign in_ready = !rst && !flush && !full;

`ifdef ISSUE_BYPASS_EN
    assign bypass    = empty && in_valid && out_ready && !flush;
    assign out_valid = !flush && (!empty || in_valid);
    assign out_entry = empty ? in_entry : slot[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign out_valid = !flush && !empty;
    assign out_entry = slot[rd_ptr];
`endif

    // A bypassed entry leaves in the same cycle, so it is never written
    assign wr_en = in_valid && in_ready && !bypass;
    assign rd_en = out_valid && out_ready && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) slot[wr_ptr] <= in_entry;
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - issue stage: one independent FIFO per execution channel
// Optional same-cycle bypass into empty channels: ISSUE_BYPASS_EN.
module issue_queue
    import typedef_pkg::*;
#(
    parameter  int NUM_CH = ISSUE_NUM_CH,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    issue_queue_if.slave                  bus,
    output logic [NUM_CH-1:0][CNT_W-1:0]  occupancy,
    output logic                          all_empty
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        issue_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_entry  (bus.in_entry[i]),
            .in_valid  (bus.in_valid[i]),
            .in_ready  (bus.in_ready[i]),
            .out_entry (bus.out_entry[i]),
            .out_valid (bus.out_valid[i]),
            .out_ready (bus.out_ready[i]),
            .count     (occupancy[i])
        );
    end

    always_comb begin
        all_empty = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (occupancy[i] != '0) all_empty = 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - vector table plus per-channel scoreboard for issue_queue
module tb_issue_queue;
    import typedef_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0][1:0]  occupancy;
    logic             all_empty;

    issue_queue_if #(.NUM_CH(3)) bus ();

    issue_queue #(.NUM_CH(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .all_empty (all_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] iv;
        logic [2:0] ordy;
        logic       fl;
        logic [2:0] ir;
        logic [2:0] ov;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        logic       ae;
    } vec_t;

    localparam int NV = 28;
    vec_t      vecs [NV];
    vec_t      v;
    RS_ENTRY_t sbq [3][$];
    RS_ENTRY_t exp_e;
    int        checks = 0;
    int        errors = 0;

    function automatic RS_ENTRY_t mk(input int row, input int ch);
        RS_ENTRY_t e;
        e.rob_tag = 6'(row);
        e.opcode  = 8'(ch);
        e.src_a   = 32'(row * 16 + ch);
        e.src_b   = ~e.src_a;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [2:0] iv, input logic [2:0] ordy, input logic fl, input int row);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        flush         = fl;
        for (int c = 0; c < 3; c++) bus.in_entry[c] = mk(row, c);
    endtask

    initial begin
        // columns: in_valid, out_ready, flush | in_ready, out_valid, occ0, occ1, occ2, all_empty
        vecs[0]  = '{3'b000, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[1]  = '{3'b001, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[2]  = '{3'b000, 3'b000, 1'b0, 3'b111, 3'b001, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[3]  = '{3'b010, 3'b000, 1'b0, 3'b111, 3'b001, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[4]  = '{3'b010, 3'b000, 1'b0, 3'b111, 3'b011, 2'd1, 2'd1, 2'd0, 1'b0};
        vecs[5]  = '{3'b010, 3'b000, 1'b0, 3'b101, 3'b011, 2'd1, 2'd2, 2'd0, 1'b0};
        vecs[6]  = '{3'b010, 3'b010, 1'b0, 3'b101, 3'b011, 2'd1, 2'd2, 2'd0, 1'b0};
        vecs[7]  = '{3'b010, 3'b010, 1'b0, 3'b111, 3'b011, 2'd1, 2'd1, 2'd0, 1'b0};
        vecs[8]  = '{3'b000, 3'b010, 1'b0, 3'b111, 3'b011, 2'd1, 2'd1, 2'd0, 1'b0};
        vecs[9]  = '{3'b000, 3'b001, 1'b0, 3'b111, 3'b001, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[10] = '{3'b000, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[11] = '{3'b100, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        for (int i = 12; i < 20; i++)
            vecs[i] = '{3'b100, 3'b100, 1'b0, 3'b111, 3'b100, 2'd0, 2'd0, 2'd1, 1'b0};
        vecs[20] = '{3'b000, 3'b100, 1'b0, 3'b111, 3'b100, 2'd0, 2'd0, 2'd1, 1'b0};
        vecs[21] = '{3'b111, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[22] = '{3'b111, 3'b000, 1'b0, 3'b111, 3'b111, 2'd1, 2'd1, 2'd1, 1'b0};
        vecs[23] = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 2'd2, 2'd2, 2'd2, 1'b0};
        vecs[24] = '{3'b000, 3'b111, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[25] = '{3'b001, 3'b001, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[26] = '{3'b000, 3'b001, 1'b0, 3'b111, 3'b001, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[27] = '{3'b000, 3'b000, 1'b0, 3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1};

        rst = 1'b1;
        drive(3'b000, 3'b000, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 96'(bus.in_ready), 96'(3'b000));
        chk("reset out_valid", 96'(bus.out_valid), 96'(3'b000));
        @(negedge clk);
        chk("reset occupancy", 96'(occupancy), 96'(6'd0));
        chk("reset all_empty", 96'(all_empty), 96'(1'b1));
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef ISSUE_BYPASS_EN
        drive(3'b100, 3'b100, 1'b0, 99);
        @(negedge clk);
        chk("bypass out_valid2", 96'(bus.out_valid[2]), 96'(1'b1));
        chk("bypass out_entry2", 96'(bus.out_entry[2]), 96'(mk(99, 2)));
        chk("bypass occ2", 96'(occupancy[2]), 96'(2'd0));
        @(posedge clk);
        #1 drive(3'b000, 3'b000, 1'b0, 0);
        @(negedge clk);
        chk("bypass occ2 after", 96'(occupancy[2]), 96'(2'd0));
        chk("bypass all_empty", 96'(all_empty), 96'(1'b1));
        chk("bypass out_valid idle", 96'(bus.out_valid), 96'(3'b000));
`else
        for (int r = 0; r < NV; r++) begin
            v = vecs[r];
            if (r != 0) begin
                @(posedge clk);
                #1;
            end
            drive(v.iv, v.ordy, v.fl, r);
            @(negedge clk);
            chk($sformatf("row%0d in_ready", r), 96'(bus.in_ready), 96'(v.ir));
            chk($sformatf("row%0d out_valid", r), 96'(bus.out_valid), 96'(v.ov));
            chk($sformatf("row%0d occupancy", r), 96'(occupancy), 96'({v.o2, v.o1, v.o0}));
            chk($sformatf("row%0d all_empty", r), 96'(all_empty), 96'(v.ae));
            for (int c = 0; c < 3; c++) begin
                if (bus.out_valid[c] && bus.out_ready[c]) begin
                    if (sbq[c].size() == 0) begin
                        chk($sformatf("row%0d ch%0d unexpected pop", r, c), 96'(1), 96'(0));
                    end else begin
                        exp_e = sbq[c].pop_front();
                        chk($sformatf("row%0d ch%0d out_entry", r, c), 96'(bus.out_entry[c]), 96'(exp_e));
                    end
                end
                if (v.iv[c] && v.ir[c]) sbq[c].push_back(mk(r, c));
            end
            if (v.fl) begin
                for (int c = 0; c < 3; c++) sbq[c].delete();
            end
        end
        for (int c = 0; c < 3; c++)
            chk($sformatf("ch%0d scoreboard drained", c), 96'(sbq[c].size()), 96'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
